// File: rtl/sad_topk_tracker.sv
// Keeps the TOP_K smallest SADs seen during one block-matching search.
// Candidates arrive in raster order. Each accepted candidate is inserted into
// a sorted list. The rank-0 winner is also reported as a signed motion vector.
module sad_topk_tracker #(
  parameter int TB_LENGTH    = 16,
  parameter int SW_LENGTH    = 64,
  parameter int PE_OUT_WIDTH = 8,
  parameter int TOP_K        = 2,
  localparam int RANGE       = SW_LENGTH - TB_LENGTH + 1,
  localparam int NUM_CAND    = RANGE * RANGE,
  localparam int CNT_WIDTH   = $clog2(NUM_CAND),
  localparam int SAD_WIDTH   = $clog2(TB_LENGTH * TB_LENGTH) + PE_OUT_WIDTH,
  localparam int MV_WIDTH    = $clog2(RANGE) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req,
  input  logic                           sad_valid,
  input  logic [SAD_WIDTH-1:0]           sad_in,
  input  logic                           early_en,
  input  logic [SAD_WIDTH-1:0]           early_thresh,
  output logic                           sad_ready,
  output logic                           ack,
  output logic                           early_hit,
  output logic [CNT_WIDTH:0]             cand_cnt,
  output logic [TOP_K*SAD_WIDTH-1:0]     min_sad,
  output logic [TOP_K*CNT_WIDTH-1:0]     min_cnt,
  output logic signed [MV_WIDTH-1:0]     min_mvx,
  output logic signed [MV_WIDTH-1:0]     min_mvy
);

  // Row and column counters need one bit less than a motion vector.
  localparam int RC_WIDTH = MV_WIDTH - 1;
  localparam logic [RC_WIDTH-1:0]  LAST_COL  = RC_WIDTH'(RANGE - 1);
  localparam logic [MV_WIDTH-1:0]  MV_OFFSET = MV_WIDTH'((RANGE - 1) / 2);
  localparam logic [CNT_WIDTH:0]   LAST_IDX  = (CNT_WIDTH + 1)'(NUM_CAND - 1);
  localparam logic [CNT_WIDTH:0]   MAX_CNT   = (CNT_WIDTH + 1)'(NUM_CAND);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e                state_q, state_d;
  logic [SAD_WIDTH-1:0]  sad_q [TOP_K];
  logic [SAD_WIDTH-1:0]  sad_d [TOP_K];
  logic [CNT_WIDTH-1:0]  idx_q [TOP_K];
  logic [CNT_WIDTH-1:0]  idx_d [TOP_K];
  logic [MV_WIDTH-1:0]   mvx_q, mvx_d, mvy_q, mvy_d;
  logic [CNT_WIDTH:0]    cnt_q, cnt_d;
  logic [RC_WIDTH-1:0]   row_q, row_d, col_q, col_d;
  logic                  early_hit_q, early_hit_d;
  logic                  ack_q;

  logic                  start, accept, is_last, thresh_hit;
  logic [TOP_K-1:0]      beats;

  // Qualify this cycle's events: search start, candidate acceptance and the stop conditions.
  always_comb begin
    start      = (state_q == IDLE) && req;
    accept     = (state_q == SCAN) && req && sad_valid;
    is_last    = (cnt_q == LAST_IDX);
    thresh_hit = early_en && (sad_in <= early_thresh);
    for (int r = 0; r < TOP_K; r++) begin
      beats[r] = (sad_in < sad_q[r]);
    end
  end

  // Next-state logic. Dropping req always returns to IDLE. In SCAN this abandons the search.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = SCAN;
      SCAN: begin
        if (!req)                                   state_d = IDLE;
        else if (accept && (is_last || thresh_hit)) state_d = DONE;
      end
      DONE:    if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sorted insertion. A strict compare means an equal SAD never displaces an earlier index.
  always_comb begin
    sad_d       = sad_q;
    idx_d       = idx_q;
    mvx_d       = mvx_q;
    mvy_d       = mvy_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    col_d       = col_q;
    early_hit_d = early_hit_q;
    if (start) begin
      for (int r = 0; r < TOP_K; r++) begin
        sad_d[r] = '1;
        idx_d[r] = '0;
      end
      mvx_d       = '0;
      mvy_d       = '0;
      cnt_d       = '0;
      row_d       = '0;
      col_d       = '0;
      early_hit_d = 1'b0;
    end else if (accept) begin
      if (beats[0]) begin
        sad_d[0] = sad_in;
        idx_d[0] = cnt_q[CNT_WIDTH-1:0];
        mvx_d    = {1'b0, col_q} - MV_OFFSET;
        mvy_d    = {1'b0, row_q} - MV_OFFSET;
      end
      for (int r = 1; r < TOP_K; r++) begin
        if (beats[r]) begin
          if (beats[r-1]) begin
            sad_d[r] = sad_q[r-1];
            idx_d[r] = idx_q[r-1];
          end else begin
            sad_d[r] = sad_in;
            idx_d[r] = cnt_q[CNT_WIDTH-1:0];
          end
        end
      end
      if (cnt_q != MAX_CNT) cnt_d = cnt_q + 1'b1;
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (thresh_hit) early_hit_d = 1'b1;
    end
  end

  // Register everything. ack mirrors the DONE state one edge after it is decided.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      early_hit_q <= 1'b0;
      cnt_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      mvx_q       <= '0;
      mvy_q       <= '0;
      for (int r = 0; r < TOP_K; r++) begin
        sad_q[r] <= '1;
        idx_q[r] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ack_q       <= (state_d == DONE);
      early_hit_q <= early_hit_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      mvx_q       <= mvx_d;
      mvy_q       <= mvy_d;
      sad_q       <= sad_d;
      idx_q       <= idx_d;
    end
  end

  // Flatten the rank arrays onto the output buses, placing rank 0 in the LSBs.
  always_comb begin
    min_sad = '0;
    min_cnt = '0;
    for (int r = 0; r < TOP_K; r++) begin
      min_sad[r*SAD_WIDTH +: SAD_WIDTH] = sad_q[r];
      min_cnt[r*CNT_WIDTH +: CNT_WIDTH] = idx_q[r];
    end
  end

  assign sad_ready = (state_q == SCAN);
  assign ack       = ack_q;
  assign early_hit = early_hit_q;
  assign cand_cnt  = cnt_q;
  assign min_mvx   = mvx_q;
  assign min_mvy   = mvy_q;

endmodule

// File: tb/tb_sad_topk_tracker.sv
// Bench for sad_topk_tracker using a 3x3 candidate grid and two ranks.
// It applies fixed vectors and hand-written corner sequences, then runs random
// searches that are checked against a sort-based reference model.
module tb_sad_topk_tracker;

  localparam int K     = 2;
  localparam int NC    = 9;
  localparam int SAD_W = 10;
  localparam int CNT_W = 4;
  localparam int MV_W  = 3;
  localparam int ONES  = 1023;

  logic                 clk;
  logic                 rst;
  logic                 req;
  logic                 sad_valid;
  logic [SAD_W-1:0]     sad_in;
  logic                 early_en;
  logic [SAD_W-1:0]     early_thresh;
  logic                 sad_ready;
  logic                 ack;
  logic                 early_hit;
  logic [CNT_W:0]       cand_cnt;
  logic [K*SAD_W-1:0]   min_sad;
  logic [K*CNT_W-1:0]   min_cnt;
  logic signed [MV_W-1:0] min_mvx;
  logic signed [MV_W-1:0] min_mvy;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    int sads[NC];
    bit earlyEn;
    int thresh;
    int expAccepted;
    bit expEarly;
    int expSad[K];
    int expCnt[K];
  } vec_t;

  vec_t vecs[5];

  sad_topk_tracker #(
    .TB_LENGTH(2), .SW_LENGTH(4), .PE_OUT_WIDTH(8), .TOP_K(K)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .sad_valid(sad_valid), .sad_in(sad_in),
    .early_en(early_en), .early_thresh(early_thresh), .sad_ready(sad_ready),
    .ack(ack), .early_hit(early_hit), .cand_cnt(cand_cnt), .min_sad(min_sad),
    .min_cnt(min_cnt), .min_mvx(min_mvx), .min_mvy(min_mvy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic r, input logic v, input int s,
                               input logic en, input int thr);
    req          = r;
    sad_valid    = v;
    sad_in       = SAD_W'(s);
    early_en     = en;
    early_thresh = SAD_W'(thr);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int rankSad(input int r);
    return int'(min_sad[r*SAD_W +: SAD_W]);
  endfunction

  function automatic int rankCnt(input int r);
    return int'(min_cnt[r*CNT_W +: CNT_W]);
  endfunction

  // Reference model: truncate at the first threshold hit, then take the K smallest (ties go to the lowest index).
  task automatic modelSearch(input int sads[NC], input bit en, input int thr,
                             output int accepted, output bit early,
                             output int es[K], output int ec[K]);
    bit used[NC];
    int best;
    accepted = NC;
    early    = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (en && sads[i] <= thr) begin
        accepted = i + 1;
        early    = 1'b1;
        break;
      end
    end
    for (int i = 0; i < NC; i++) used[i] = 1'b0;
    for (int r = 0; r < K; r++) begin
      best = -1;
      for (int i = 0; i < accepted; i++) begin
        if (!used[i] && sads[i] < ONES && (best < 0 || sads[i] < sads[best])) best = i;
      end
      if (best < 0) begin
        es[r] = ONES;
        ec[r] = 0;
      end else begin
        es[r] = sads[best];
        ec[r] = best;
        used[best] = 1'b1;
      end
    end
  endtask

  // Start a search and stream 'count' candidates. ack must rise only after the last one.
  task automatic runSearch(input int sads[NC], input int count, input bit en,
                           input int thr, input bit gaps);
    applyStimulus(1, 0, 0, en, thr);
    checkOutput("sad_ready_scan", int'(sad_ready), 1);
    checkOutput("start_cand_cnt", int'(cand_cnt), 0);
    for (int i = 0; i < count; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        applyStimulus(1, 0, int'($urandom_range(0, 1022)), en, thr);
        checkOutput("ack_during_gap", int'(ack), 0);
      end
      applyStimulus(1, 1, sads[i], en, thr);
      checkOutput("ack_timing", int'(ack), (i == count - 1) ? 1 : 0);
    end
    sad_valid = 1'b0;
  endtask

  // Compare the final search results against the expected ranks and the motion vector.
  task automatic checkResults(input int accepted, input bit early,
                              input int es[K], input int ec[K]);
    checkOutput("ack_done", int'(ack), 1);
    checkOutput("cand_cnt", int'(cand_cnt), accepted);
    checkOutput("early_hit", int'(early_hit), int'(early));
    for (int r = 0; r < K; r++) begin
      checkOutput($sformatf("rank%0d_sad", r), rankSad(r), es[r]);
      checkOutput($sformatf("rank%0d_cnt", r), rankCnt(r), ec[r]);
    end
    checkOutput("min_mvx", int'(min_mvx), (ec[0] % 3) - 1);
    checkOutput("min_mvy", int'(min_mvy), (ec[0] / 3) - 1);
  endtask

  // Release req and confirm that ack drops on the very next edge.
  task automatic finishSearch();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("ack_release", int'(ack), 0);
    checkOutput("idle_ready", int'(sad_ready), 0);
  endtask

  initial begin
    int  sads[NC];
    int  acc;
    bit  early;
    int  es[K];
    int  ec[K];
    int  held;

    vecs[0] = '{sads: '{50,40,30,20,10,60,70,80,90}, earlyEn: 0, thresh: 0,
                expAccepted: 9, expEarly: 0, expSad: '{10,20}, expCnt: '{4,3}};
    vecs[1] = '{sads: '{5,5,5,5,5,5,5,5,5}, earlyEn: 0, thresh: 0,
                expAccepted: 9, expEarly: 0, expSad: '{5,5}, expCnt: '{0,1}};
    vecs[2] = '{sads: '{50,12,0,0,0,0,0,0,0}, earlyEn: 1, thresh: 15,
                expAccepted: 2, expEarly: 1, expSad: '{12,50}, expCnt: '{1,0}};
    vecs[3] = '{sads: '{50,40,30,20,10,60,70,80,3}, earlyEn: 1, thresh: 5,
                expAccepted: 9, expEarly: 1, expSad: '{3,10}, expCnt: '{8,4}};
    vecs[4] = '{sads: '{7,1,1,1,1,1,1,1,1}, earlyEn: 1, thresh: 7,
                expAccepted: 1, expEarly: 1, expSad: '{7,ONES}, expCnt: '{0,0}};

    req = 0; sad_valid = 0; sad_in = '0; early_en = 0; early_thresh = '0;

    // Power-on reset held for two cycles.
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("reset_ack", int'(ack), 0);
    checkOutput("reset_ready", int'(sad_ready), 0);
    checkOutput("reset_early", int'(early_hit), 0);
    checkOutput("reset_cand_cnt", int'(cand_cnt), 0);
    checkOutput("reset_rank0_sad", rankSad(0), ONES);
    checkOutput("reset_rank1_sad", rankSad(1), ONES);
    checkOutput("reset_rank0_cnt", rankCnt(0), 0);
    checkOutput("reset_mvx", int'(min_mvx), 0);
    rst = 1'b0;

    // Fixed vectors: full search, ties, early stop, both stop causes together, threshold equality.
    for (int v = 0; v < 5; v++) begin
      runSearch(vecs[v].sads, vecs[v].expAccepted, vecs[v].earlyEn, vecs[v].thresh, 1'b0);
      checkResults(vecs[v].expAccepted, vecs[v].expEarly, vecs[v].expSad, vecs[v].expCnt);
      if (v == 0) begin
        held = 0;
        for (int c = 0; c < 10; c++) begin
          applyStimulus(1, 1, 1, 0, 0);
          if (ack === 1'b1 && rankSad(0) == 10 && cand_cnt == 9) held++;
        end
        checkOutput("ack_held_10_cycles", held, 10);
      end
      finishSearch();
    end

    // Abort with gaps in sad_valid. Partial results hold, and IDLE ignores sad_valid.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 9, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 8, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 7, 0, 0);
    checkOutput("gap_no_ack", int'(ack), 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("abort_ack", int'(ack), 0);
    checkOutput("abort_idle", int'(sad_ready), 0);
    checkOutput("abort_cand_cnt", int'(cand_cnt), 3);
    checkOutput("abort_rank0_sad", rankSad(0), 7);
    checkOutput("abort_rank0_cnt", rankCnt(0), 2);
    checkOutput("abort_rank1_cnt", rankCnt(1), 1);
    checkOutput("abort_mvx", int'(min_mvx), 1);
    checkOutput("abort_mvy", int'(min_mvy), -1);
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("idle_valid_cand_cnt", int'(cand_cnt), 3);
    checkOutput("idle_valid_rank0", rankSad(0), 7);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("restart_rank0_sad", rankSad(0), ONES);
    checkOutput("restart_rank1_sad", rankSad(1), ONES);
    checkOutput("restart_rank0_cnt", rankCnt(0), 0);
    checkOutput("restart_cand_cnt", int'(cand_cnt), 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Reset in the middle of a scan overrides req and sad_valid.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 3, 0, 0);
    applyStimulus(1, 1, 4, 0, 0);
    rst = 1'b1;
    applyStimulus(1, 1, 2, 0, 0);
    checkOutput("midrst_ready", int'(sad_ready), 0);
    checkOutput("midrst_cand_cnt", int'(cand_cnt), 0);
    checkOutput("midrst_rank0_sad", rankSad(0), ONES);
    checkOutput("midrst_rank0_cnt", rankCnt(0), 0);
    checkOutput("midrst_mvy", int'(min_mvy), 0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);

    // Random searches with random gaps, compared against the reference model.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < NC; i++) sads[i] = int'($urandom_range(0, 40));
      early_en = 1'($urandom_range(0, 1));
      held     = int'($urandom_range(0, 12));
      modelSearch(sads, early_en, held, acc, early, es, ec);
      runSearch(sads, acc, early_en, held, 1'b1);
      checkResults(acc, early, es, ec);
      finishSearch();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
